// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// display_pkg : shared types and constants for the display scheduler
// Rev 1.0
// ============================================================================
package display_pkg;

  localparam int NUM_SRC = 4;

  typedef logic [1:0] src_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  localparam src_idx_t SRC_PC  = 2'd0;
  localparam src_idx_t SRC_REG = 2'd1;
  localparam src_idx_t SRC_MEM = 2'd2;
  localparam src_idx_t SRC_IO  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/display_rr_pick.sv
`default_nettype none
// ============================================================================
// display_rr_pick : first source with data after ptr, wrapping modulo 4
// Rev 1.0
// ============================================================================
module display_rr_pick
  import display_pkg::*;
(
  input  logic [3:0] has,
  input  src_idx_t   ptr,
  output src_idx_t   next,
  output logic       found
);

  src_idx_t w_idx;

  // Scan from farthest to nearest so the nearest candidate wins;
  // distance 4 wraps back onto ptr itself.
  always_comb begin
    found = |has;
    next  = ptr;
    w_idx = ptr;
    for (int k = NUM_SRC; k >= 1; k--) begin
      w_idx = ptr + src_idx_t'(k);
      if (has[w_idx]) next = w_idx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/display_scheduler.sv
`default_nettype none
// ============================================================================
// display_scheduler : round-robin time-sharing of a 4-digit display among
// four req/ack-loaded 16-bit sources, with dwell, blank gap and pin override.
// Rev 1.0
// ============================================================================
module display_scheduler
  import display_pkg::*;
#(
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int BLANK_CYCLES = 1000
)
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_SRC-1:0]    src_req,
  input  logic [16*NUM_SRC-1:0] src_data,
  output logic [NUM_SRC-1:0]    src_ack,
  input  logic                  pin_en,
  input  src_idx_t              pin_sel,
  output logic                  disp_on,
  output logic [15:0]           disp_number,
  output src_idx_t              disp_src
);

  localparam int MAX_CNT = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);

  logic [15:0]        r_val [NUM_SRC];
  logic [NUM_SRC-1:0] r_has;
  logic [NUM_SRC-1:0] r_ack;
  state_t             r_state;
  src_idx_t           r_cur;
  src_idx_t           r_ptr;
  logic [CW-1:0]      r_cnt;
  logic               r_on;
  logic [15:0]        r_num;

  state_t        w_state_n;
  src_idx_t      w_cur_n;
  src_idx_t      w_ptr_n;
  logic [CW-1:0] w_cnt_n;
  src_idx_t      w_pick_ptr;
  src_idx_t      w_next;
  logic          w_found;
  logic          w_pin;

  // While showing, search after cur for "another source"; otherwise after ptr.
  assign w_pick_ptr = (r_state == SHOW) ? r_cur : r_ptr;
  assign w_pin      = pin_en && r_has[pin_sel];

  display_rr_pick u_pick (
    .has   (r_has),
    .ptr   (w_pick_ptr),
    .next  (w_next),
    .found (w_found)
  );

  always_comb begin
    w_state_n = r_state;
    w_cur_n   = r_cur;
    w_ptr_n   = r_ptr;
    w_cnt_n   = r_cnt;
    if (w_pin) begin
      w_state_n = SHOW;
      w_cur_n   = pin_sel;
      w_cnt_n   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            w_state_n = SHOW;
            w_cur_n   = w_next;
            w_cnt_n   = '0;
          end
        end
        SHOW: begin
          if (r_cnt == DWELL_LAST) begin
            w_cnt_n = '0;
            if (w_found && (w_next != r_cur)) begin
              w_ptr_n = r_cur;
              if (BLANK_CYCLES == 0) w_cur_n = w_next;
              else                   w_state_n = BLANK;
            end
          end else begin
            w_cnt_n = r_cnt + CW'(1);
          end
        end
        BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            w_state_n = SHOW;
            w_cur_n   = w_next;
            w_cnt_n   = '0;
          end else begin
            w_cnt_n = r_cnt + CW'(1);
          end
        end
        default: begin
          w_state_n = IDLE;
          w_cnt_n   = '0;
        end
      endcase
    end
  end

  // Latches and one-cycle acks; a held request re-acks every second cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SRC; i++) r_val[i] <= '0;
      r_has <= '0;
      r_ack <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        r_ack[i] <= src_req[i] && !r_ack[i];
        if (src_req[i] && !r_ack[i]) begin
          r_val[i] <= src_data[16*i +: 16];
          r_has[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cur   <= SRC_PC;
      r_ptr   <= SRC_IO;
      r_cnt   <= '0;
      r_on    <= 1'b0;
      r_num   <= '0;
    end else begin
      r_state <= w_state_n;
      r_cur   <= w_cur_n;
      r_ptr   <= w_ptr_n;
      r_cnt   <= w_cnt_n;
      r_on    <= (w_state_n == SHOW);
      if (w_state_n == SHOW) r_num <= r_val[w_cur_n];
    end
  end

  assign src_ack     = r_ack;
  assign disp_on     = r_on;
  assign disp_number = r_num;
  assign disp_src    = r_cur;

endmodule
`default_nettype wire
